dmem_uart_tx: RTL and testbench

- Memory-mapped UART transmitter.
- Acts as a responder on the core's data-memory bus, alongside the RAM.
- The core writes bytes to a TX data register. The block buffers them in a small FIFO and serialises them 8N1, LSB first, on TXD.
- Status is readable over the same bus. HIT tells the top-level to select this block's read data instead of the RAM's.

---
 rtl/dmem_uart_pkg.sv | 30 +++
 rtl/tx_fifo.sv | 73 +++++++
 rtl/dmem_uart_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_uart_pkg.sv
// -----------------------------------------------------------------------------
// dmem_uart_pkg
// Shared types and constants for the memory-mapped UART transmitter.
//   tx_state_t       : transmitter FSM states. PARITY exists in every build but
//                      is only reachable when DMEM_UART_TX_PARITY_EN is defined.
//   REG_TXDATA/STATUS: word offsets from BASE_ADDR.
//   STAT_*           : bit positions inside the STATUS read word.
// -----------------------------------------------------------------------------
package dmem_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned REG_TXDATA = 0;
    localparam int unsigned REG_STATUS = 1;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;
    localparam int unsigned STAT_COUNT_W   = 4;
    localparam int unsigned STAT_PAR_CAP   = 8;

endpackage

// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Small synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   push, din     : write request and byte; ignored when full unless a pop
//                   happens in the same cycle (the freed slot is reused)
//   pop, dout     : read request; dout always shows the head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries (wr_ptr - rd_ptr)
// Pointers carry one extra bit so full and empty are distinguishable; they
// wrap naturally. Reset only clears the pointers, the storage is left as is.
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (count == PTR_DEPTH);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the head slot, so a push while full
        // still fits.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/dmem_uart_tx.sv
// -----------------------------------------------------------------------------
// dmem_uart_tx
// UART transmitter sitting on the core's data-memory bus next to the RAM.
// Bytes written to TXDATA are queued in tx_fifo and sent 8N1, LSB first.
// Optional feature macro: DMEM_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit and sets STATUS[8].
// Ports:
//   CLK      : system clock, rising edge
//   RSTa     : asynchronous reset, active high
//   ADDRESS  : bus word address
//   DATA_IN  : bus write data (TXDATA uses [7:0], STATUS write uses [3])
//   READ     : bus read strobe
//   WRITE    : bus write strobe, sampled on rising CLK
//   DATA_OUT : combinational read data, zero unless READ && HIT
//   HIT      : ADDRESS is one of this block's two registers
//   TXD      : serial output, idle high
// Register map (word offsets from BASE_ADDR):
//   0 TXDATA : write pushes DATA_IN[7:0], reads as 0
//   1 STATUS : {count[7:4], OVF[3], EMPTY[2], FULL[1], BUSY[0]};
//              writing 1 to bit 3 clears OVF
// -----------------------------------------------------------------------------
module dmem_uart_tx
    import dmem_uart_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h3F0,
    parameter int                CLKS_PER_BIT = 434,
    parameter int                FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RSTa,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              READ,
    input  logic              WRITE,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              HIT,
    output logic              TXD
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int               FAW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ADDR_W-1:0] offset;
    logic              hit;
    logic              wr_txdata, wr_status;

    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FAW:0]      fifo_count;

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;
    logic              baud_done;
    logic              busy;
    logic [DATA_W-1:0] status_word;
`ifdef DMEM_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Only DATA_IN[7:0] and the OVF-clear bit carry meaning.
    logic unused_data_hi;
    assign unused_data_hi = &{1'b0, DATA_IN[DATA_W-1:8]};

    // Offset arithmetic keeps the window check to one compare.
    assign offset    = ADDRESS - BASE_ADDR;
    assign hit       = (offset < ADDR_W'(2));
    assign HIT       = hit;
    assign wr_txdata = WRITE && hit && (offset == ADDR_W'(REG_TXDATA));
    assign wr_status = WRITE && hit && (offset == ADDR_W'(REG_STATUS));

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RSTa),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (DATA_IN[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_done = (cnt_q == CNT_LAST);
    assign busy      = (state_q != IDLE) || !fifo_empty;

    // TXD is registered from the current state, so the line lags the FSM by
    // one cycle: a write edge shows up as a falling TXD two edges later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
        fifo_pop  = 1'b0;
`ifdef DMEM_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = baud_done ? '0 : (cnt_q + CNT_ONE);
        end

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                    cnt_d    = '0;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef DMEM_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
`ifdef DMEM_UART_TX_PARITY_EN
                txd_d = parity_q;
                if (baud_done) begin
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                txd_d = 1'b1;
                if (baud_done) begin
                    // Chain straight into the next frame when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fifo_pop) begin
            shift_d  = fifo_dout;
`ifdef DMEM_UART_TX_PARITY_EN
            // Captured at load time because the shift register is consumed.
            parity_d = ^fifo_dout;
`endif
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && DATA_IN[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_OVF]   = ovf_q;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
`ifdef DMEM_UART_TX_PARITY_EN
        status_word[STAT_PAR_CAP] = 1'b1;
`endif
        DATA_OUT = '0;
        if (READ && hit && (offset == ADDR_W'(REG_STATUS))) begin
            DATA_OUT = status_word;
        end
    end

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q  <= shift_d;
`ifdef DMEM_UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign TXD = txd_q;

endmodule

// File: tb/tb_dmem_uart_tx.sv
module tb_dmem_uart_tx;

    localparam int         DATA_W = 32;
    localparam int         ADDR_W = 10;
    localparam logic [9:0] BASE   = 10'h3F0;
    localparam int         CPB    = 4;
    localparam int         DEPTH  = 4;
    localparam int         LIMIT  = 5000;
`ifdef DMEM_UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
    localparam logic [31:0] PAR_FLAG = 32'h100;
`else
    localparam int          NBITS    = 10;
    localparam logic [31:0] PAR_FLAG = 32'h0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic              CLK = 1'b0;
    logic              RSTa;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] DATA_IN;
    logic              READ;
    logic              WRITE;
    logic [DATA_W-1:0] DATA_OUT;
    logic              HIT;
    logic              TXD;

    dmem_uart_tx #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RSTa     (RSTa),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .READ     (READ),
        .WRITE    (WRITE),
        .DATA_OUT (DATA_OUT),
        .HIT      (HIT),
        .TXD      (TXD)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          starts_q[$];
    int          frames_rx = 0;
    bit          mon_busy = 1'b0;
    logic [10:0] last_bits = '0;
    int          wr_cyc = 0;

    typedef struct {
        string       name;
        logic [9:0]  addr;
        logic        rd;
        logic        exp_hit;
        logic [31:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial receiver: samples every bit at its centre and scores the byte
    // against the queue of bytes the bench expects to go out.
    initial begin : monitor
        logic        prev;
        logic [10:0] bits;
        logic [7:0]  b;
        logic [7:0]  e;
        bit          aborted;
        int          st;
        prev = 1'b1;
        forever begin
            @(posedge CLK); #2;
            if (prev === 1'b1 && TXD === 1'b0 && RSTa === 1'b0) begin
                mon_busy = 1'b1;
                st       = cyc;
                aborted  = 1'b0;
                bits     = '0;
                for (int k = 0; k < NBITS; k++) begin
                    repeat ((k == 0) ? 2 : CPB) begin
                        @(posedge CLK); #2;
                        if (RSTa === 1'b1) aborted = 1'b1;
                    end
                    bits[k] = TXD;
                end
                @(posedge CLK); #2;
                if (RSTa === 1'b1) aborted = 1'b1;
                prev = TXD;
                if (!aborted) begin
                    frames_rx++;
                    starts_q.push_back(st);
                    last_bits = bits;
                    b = bits[8:1];
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[NBITS-1]), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got byte %h, expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e));
`ifdef DMEM_UART_TX_PARITY_EN
                        check("parity_bit", 32'(bits[9]), 32'(^e));
`endif
                    end
                end
                mon_busy = 1'b0;
            end else begin
                prev = TXD;
            end
        end
    end

    task automatic bus_write(input logic [9:0] off, input logic [31:0] d);
        ADDRESS = BASE + off;
        DATA_IN = d;
        WRITE   = 1'b1;
        @(posedge CLK); #1;
        WRITE   = 1'b0;
        wr_cyc  = cyc;
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(10'd0, {24'd0, b});
    endtask

    task automatic read_status(output logic [31:0] v);
        ADDRESS = BASE + 10'd1;
        READ    = 1'b1;
        #1;
        v       = DATA_OUT;
        READ    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < LIMIT) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain_within_budget", 32'(n < LIMIT), 32'd1);
        wait_cycles(4);
    endtask

    initial begin : main
        vec_t        vecs[6];
        logic [31:0] v;
        logic [10:0] exp_bits;
        int          s0, w0, fr0;

        RSTa    = 1'b1;
        ADDRESS = '0;
        DATA_IN = '0;
        READ    = 1'b0;
        WRITE   = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTa = 1'b0;
        @(posedge CLK); #1;

        // Reset state and address decode
        check("txd_after_reset", 32'(TXD), 32'd1);
        vecs[0] = '{"status_read",   BASE + 10'd1, 1'b1, 1'b1, 32'h4 | PAR_FLAG};
        vecs[1] = '{"base_plus_2",   BASE + 10'd2, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{"txdata_read",   BASE,         1'b1, 1'b1, 32'h0};
        vecs[3] = '{"status_no_rd",  BASE + 10'd1, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{"base_minus_1",  BASE - 10'd1, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{"addr_zero",     10'h000,      1'b1, 1'b0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            ADDRESS = vecs[i].addr;
            READ    = vecs[i].rd;
            #1;
            check({vecs[i].name, "_hit"}, 32'(HIT), 32'(vecs[i].exp_hit));
            check({vecs[i].name, "_dout"}, DATA_OUT, vecs[i].exp_dout);
            READ = 1'b0;
        end

        // Single frame 0xA5: latency, bit pattern, BUSY at end of frame
        s0 = starts_q.size();
        send(8'hA5);
        w0 = wr_cyc;
        wait_cycles(FRAME);
        read_status(v);
        check("busy_late_in_frame", v & 32'h1, 32'h1);
        wait_cycles(2);
        read_status(v);
        check("status_after_frame", v, 32'h4 | PAR_FLAG);
        wait_drain();
        check("a5_frame_count", 32'(starts_q.size()), 32'(s0 + 1));
        if (starts_q.size() > s0) begin
            check("first_fall_latency", 32'(starts_q[s0] - w0), 32'd2);
        end
`ifdef DMEM_UART_TX_PARITY_EN
        exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        exp_bits = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        check("a5_bit_samples", 32'(last_bits), 32'(exp_bits));

        // Three bytes back to back, count stepping down
        s0 = starts_q.size();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        read_status(v);
        check("count_after_3", (v >> 4) & 32'hF, 32'd2);
        wait_cycles(FRAME + 5);
        read_status(v);
        check("count_after_1st", (v >> 4) & 32'hF, 32'd1);
        wait_cycles(FRAME);
        read_status(v);
        check("count_after_2nd", (v >> 4) & 32'hF, 32'd0);
        wait_drain();
        check("b2b_frame_count", 32'(starts_q.size()), 32'(s0 + 3));
        if (starts_q.size() >= s0 + 3) begin
            check("b2b_gap_1", 32'(starts_q[s0+1] - starts_q[s0]), 32'(FRAME));
            check("b2b_gap_2", 32'(starts_q[s0+2] - starts_q[s0+1]), 32'(FRAME));
        end

        // Overflow: six writes in six cycles while the FSM is busy
        send(8'h11);
        send(8'h12);
        send(8'h13);
        send(8'h14);
        send(8'h15);
        bus_write(10'd0, 32'h16);
        read_status(v);
        check("status_overflow", v, 32'h4B | PAR_FLAG);
        bus_write(10'd1, 32'hFFFF_FFF7);
        read_status(v);
        check("ovf_kept_bit3_zero", v & 32'h8, 32'h8);
        bus_write(10'd1, 32'h8);
        read_status(v);
        check("status_ovf_cleared", v, 32'h43 | PAR_FLAG);
        wait_drain();

        // Frame length with two different bytes, parity-capable flag
        s0 = starts_q.size();
        send(8'h07);
        send(8'hFF);
        read_status(v);
        check("par_cap_flag", v & 32'h100, PAR_FLAG);
        wait_drain();
        if (starts_q.size() >= s0 + 2) begin
            check("frame_length", 32'(starts_q[s0+1] - starts_q[s0]), 32'(FRAME));
        end else begin
            check("frame_length_count", 32'(starts_q.size()), 32'(s0 + 2));
        end

        // Reset in the middle of the data bits with two bytes queued
        bus_write(10'd0, 32'h00);
        bus_write(10'd0, 32'hAA);
        bus_write(10'd0, 32'h55);
        wait_cycles(10);
        check("txd_mid_data", 32'(TXD), 32'd0);
        #3 RSTa = 1'b1;
        #1;
        check("txd_async_reset", 32'(TXD), 32'd1);
        @(posedge CLK);
        @(posedge CLK);
        #3 RSTa = 1'b0;
        @(posedge CLK); #1;
        read_status(v);
        check("status_after_reset", v, 32'h4 | PAR_FLAG);
        fr0 = frames_rx;
        wait_cycles(3 * FRAME);
        check("no_frames_after_reset", 32'(frames_rx), 32'(fr0));
        check("txd_idle_after_reset", 32'(TXD), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
